lsu_arbiter: RTL and testbench
==============================

Name: lsu_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single lsu port.
- Master 0 is the core load/store path. Master 1 is an auxiliary requester (debug loader / DMA into data memory or I/O at 0x7000–0x78FF).
- Serialises one transaction at a time, drives the lsu command pins for exactly one cycle per transaction, and returns load data to the winning master after a fixed read latency.
- Fixed priority to master 0, with a starvation guard for master 1.

Parameters:
- RD_LAT, 1, cycles from the lsu read-command cycle to valid i_ld_data (legal range 1–7)
- MAX_HOLD, 4, consecutive contested master-0 grants allowed before master 1 is forced to win (legal range 1–15)

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_mX_req  in  1  request; hold stable until o_mX_gnt is seen (X = 0, 1 for all master ports)
- i_mX_wren  in  1  1 = store, 0 = load
- i_mX_addr  in  32  byte address
- i_mX_mask  in  4  byte-lane mask
- i_mX_un  in  1  unsigned-load flag
- i_mX_wdata  in  32  store data
- o_mX_gnt  out  1  one-cycle pulse; command accepted
- o_mX_rvalid  out  1  one-cycle pulse; o_mX_rdata valid
- o_mX_rdata  out  32  load data, held until the next rvalid for that master
- o_lsu_addr  out  32  to lsu i_lsu_addr
- o_lsu_mask  out  4  to lsu i_mask
- o_lsu_un  out  1  to lsu i_lsu_un
- o_lsu_wren  out  1  to lsu i_lsu_wren
- o_lsu_rden  out  1  to lsu i_lsu_rden
- o_st_data  out  32  to lsu i_st_data
- i_ld_data  in  32  from lsu o_ld_data
- o_busy  out  1  high in any state other than IDLE

Behaviour:
Reset:
- Asserting i_rst forces state IDLE, clears all outputs, o_mX_rdata, the hold counter and all command registers.
- A read in flight is dropped; no rvalid is ever issued for it.

States:
- IDLE
  - No request: stay in IDLE.
  - Any request: pick a winner, latch its addr, mask, un, wren and wdata plus a winner-id bit.
  - Pulse o_winner_gnt in this same cycle, then go to ISSUE.
- ISSUE
  - Exactly one cycle.
  - Drive o_lsu_addr, mask, un and o_st_data from the latched registers.
  - Drive o_lsu_wren = latched wren and o_lsu_rden = ~latched wren.
  - Next state: store → IDLE; load → RDWAIT with the latency counter at 1.
- RDWAIT
  - Hold o_lsu_addr, mask and un stable, with wren = rden = 0.
  - Increment the counter each cycle.
  - In the cycle the counter equals RD_LAT, register i_ld_data into o_winner_rdata.
  - o_winner_rvalid is high the following cycle, concurrent with the return to IDLE. That IDLE cycle may already grant a new request.

Idle values:
- o_lsu_wren and o_lsu_rden are 0 outside ISSUE.
- o_lsu_addr, mask, un and o_st_data hold their last value.

Throughput:
- Store: 2 cycles per transaction.
- Load: 2 + RD_LAT cycles. Load-to-rvalid is RD_LAT + 1 cycles after ISSUE.

Arbitration (evaluated in IDLE only):
- Only one req high → that master wins.
- Both high and hold_cnt < MAX_HOLD → master 0 wins, and hold_cnt increments.
- Both high and hold_cnt == MAX_HOLD → master 1 wins.
- Any master-1 grant clears hold_cnt to 0.
- A master-0 grant with i_m1_req low also clears hold_cnt to 0.
- hold_cnt saturates at MAX_HOLD.

Boundary conditions:
- Requests arriving in ISSUE or RDWAIT are not granted; they are arbitrated in the next IDLE cycle.
- A requester dropping req before its gnt is legal; nothing is latched for it.
- o_mX_gnt and o_mX_rvalid for the same master may be high in the same cycle (back-to-back load); they refer to different transactions.
- Data and addresses pass through unmodified. Sign/zero extension and address decode remain in lsu.

Test Plan:
1. Master-0 store: i_m0_req=1, wren=1, addr=0x7000, wdata=0xFFFFFFFF, mask=1111.
   - o_m0_gnt pulses in cycle T.
   - At T+1: o_lsu_wren=1, o_lsu_addr=0x7000, o_st_data=0xFFFFFFFF.
   - At T+2: o_busy=0.
2. Master-1 load with RD_LAT=1: addr=0x7800, lsu returns 0xA5A5A5A5.
   - o_lsu_rden=1 at T+1.
   - o_m1_rvalid=1 and o_m1_rdata=0xA5A5A5A5 at T+3.
   - o_m0_rvalid stays 0.
3. Contention with both reqs held high, all stores, MAX_HOLD=4:
   - Grant order is m0,m0,m0,m0,m1,m0,m0,m0,m0,m1.
   - Grants occur every 2 cycles.
4. Pass-through of byte controls: master-0 load, addr=0x2003, mask=0001, un=1.
   - ISSUE shows o_lsu_mask=0001 and o_lsu_un=1.
   - A master-1 req raised during RDWAIT is granted in the IDLE cycle coinciding with o_m0_rvalid.
5. i_rst asserted mid-RDWAIT:
   - Outputs go to 0 asynchronously.
   - No rvalid appears after release.
   - The next request is granted normally with hold_cnt=0.
6. Back-to-back master-0 loads to 0x2000 (0xA1A1A1A1) then 0x2004 (0xB2B2B2B2):
   - Each rdata matches its address.
   - rvalid pulses are exactly 3 cycles apart.

Source files
------------

// File: rtl/lsu_arbiter.sv
// Two-master arbiter/sequencer in front of the single lsu port: one transaction at a time,
// fixed priority to master 0 with a starvation guard that forces master 1 through after MAX_HOLD wins.
//
//   state  | meaning
//   IDLE   | arbitrate, pulse winner gnt, latch its command
//   ISSUE  | drive lsu command pins for one cycle
//   RDWAIT | count read latency, capture i_ld_data for the winner
module lsu_arbiter #(
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_m0_req,
  input  logic        i_m0_wren,
  input  logic [31:0] i_m0_addr,
  input  logic [3:0]  i_m0_mask,
  input  logic        i_m0_un,
  input  logic [31:0] i_m0_wdata,
  output logic        o_m0_gnt,
  output logic        o_m0_rvalid,
  output logic [31:0] o_m0_rdata,
  input  logic        i_m1_req,
  input  logic        i_m1_wren,
  input  logic [31:0] i_m1_addr,
  input  logic [3:0]  i_m1_mask,
  input  logic        i_m1_un,
  input  logic [31:0] i_m1_wdata,
  output logic        o_m1_gnt,
  output logic        o_m1_rvalid,
  output logic [31:0] o_m1_rdata,
  output logic [31:0] o_lsu_addr,
  output logic [3:0]  o_lsu_mask,
  output logic        o_lsu_un,
  output logic        o_lsu_wren,
  output logic        o_lsu_rden,
  output logic [31:0] o_st_data,
  input  logic [31:0] i_ld_data,
  output logic        o_busy
);

  localparam logic [2:0] RD_LAT_C   = 3'(RD_LAT);
  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mask_q, mask_d;
  logic        un_q, un_d;
  logic        wren_q, wren_d;
  logic        win_q, win_d;
  logic [2:0]  lat_q, lat_d;
  logic [3:0]  hold_q, hold_d;
  logic        rv0_q, rv0_d;
  logic        rv1_q, rv1_d;
  logic [31:0] rd0_q, rd0_d;
  logic [31:0] rd1_q, rd1_d;
  logic        gnt0, gnt1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      un_q    <= 1'b0;
      wren_q  <= 1'b0;
      win_q   <= 1'b0;
      lat_q   <= '0;
      hold_q  <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
      rd0_q   <= '0;
      rd1_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      un_q    <= un_d;
      wren_q  <= wren_d;
      win_q   <= win_d;
      lat_q   <= lat_d;
      hold_q  <= hold_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    un_d    = un_q;
    wren_d  = wren_q;
    win_d   = win_q;
    lat_d   = lat_q;
    hold_d  = hold_q;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_m0_req || i_m1_req) begin
          state_d = ISSUE;
          // hold_q never passes MAX_HOLD: at MAX_HOLD a contested cycle goes to master 1
          if (i_m0_req && (!i_m1_req || hold_q < MAX_HOLD_C)) begin
            gnt0    = 1'b1;
            win_d   = 1'b0;
            addr_d  = i_m0_addr;
            wdata_d = i_m0_wdata;
            mask_d  = i_m0_mask;
            un_d    = i_m0_un;
            wren_d  = i_m0_wren;
            hold_d  = i_m1_req ? hold_q + 4'd1 : 4'd0;
          end else begin
            gnt1    = 1'b1;
            win_d   = 1'b1;
            addr_d  = i_m1_addr;
            wdata_d = i_m1_wdata;
            mask_d  = i_m1_mask;
            un_d    = i_m1_un;
            wren_d  = i_m1_wren;
            hold_d  = 4'd0;
          end
        end
      end
      ISSUE: begin
        if (wren_q) begin
          state_d = IDLE;
        end else begin
          state_d = RDWAIT;
          lat_d   = 3'd1;
        end
      end
      RDWAIT: begin
        if (lat_q == RD_LAT_C) begin
          state_d = IDLE;
          if (win_q) begin
            rd1_d = i_ld_data;
            rv1_d = 1'b1;
          end else begin
            rd0_d = i_ld_data;
            rv0_d = 1'b1;
          end
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // grant is combinational off IDLE; mask it so nothing is accepted while reset is held
  assign o_m0_gnt    = gnt0 & ~i_rst;
  assign o_m1_gnt    = gnt1 & ~i_rst;
  assign o_m0_rvalid = rv0_q;
  assign o_m1_rvalid = rv1_q;
  assign o_m0_rdata  = rd0_q;
  assign o_m1_rdata  = rd1_q;
  assign o_lsu_addr  = addr_q;
  assign o_lsu_mask  = mask_q;
  assign o_lsu_un    = un_q;
  assign o_st_data   = wdata_q;
  assign o_lsu_wren  = (state_q == ISSUE) & wren_q;
  assign o_lsu_rden  = (state_q == ISSUE) & ~wren_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_lsu_arbiter.sv
// Scoreboard bench for lsu_arbiter: directed stimulus pushes expected grants, lsu commands and
// read returns; a negedge monitor pops and compares whenever the DUT presents one.
module tb_lsu_arbiter;
  localparam int unsigned RD_LAT   = 1;
  localparam int unsigned MAX_HOLD = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_m0_req, i_m0_wren, i_m0_un;
  logic [31:0] i_m0_addr, i_m0_wdata;
  logic [3:0]  i_m0_mask;
  logic        i_m1_req, i_m1_wren, i_m1_un;
  logic [31:0] i_m1_addr, i_m1_wdata;
  logic [3:0]  i_m1_mask;
  logic        o_m0_gnt, o_m0_rvalid, o_m1_gnt, o_m1_rvalid;
  logic [31:0] o_m0_rdata, o_m1_rdata;
  logic [31:0] o_lsu_addr, o_st_data;
  logic [3:0]  o_lsu_mask;
  logic        o_lsu_un, o_lsu_wren, o_lsu_rden, o_busy;
  logic [31:0] i_ld_data = 32'hBAD0_BAD0;

  lsu_arbiter #(.RD_LAT(RD_LAT), .MAX_HOLD(MAX_HOLD)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_m0_req(i_m0_req), .i_m0_wren(i_m0_wren), .i_m0_addr(i_m0_addr), .i_m0_mask(i_m0_mask),
    .i_m0_un(i_m0_un), .i_m0_wdata(i_m0_wdata), .o_m0_gnt(o_m0_gnt), .o_m0_rvalid(o_m0_rvalid),
    .o_m0_rdata(o_m0_rdata),
    .i_m1_req(i_m1_req), .i_m1_wren(i_m1_wren), .i_m1_addr(i_m1_addr), .i_m1_mask(i_m1_mask),
    .i_m1_un(i_m1_un), .i_m1_wdata(i_m1_wdata), .o_m1_gnt(o_m1_gnt), .o_m1_rvalid(o_m1_rvalid),
    .o_m1_rdata(o_m1_rdata),
    .o_lsu_addr(o_lsu_addr), .o_lsu_mask(o_lsu_mask), .o_lsu_un(o_lsu_un),
    .o_lsu_wren(o_lsu_wren), .o_lsu_rden(o_lsu_rden), .o_st_data(o_st_data),
    .i_ld_data(i_ld_data), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc++;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct { bit id; int gap; bit rv; } gexp_t;
  typedef struct { bit wr; logic [31:0] addr; logic [3:0] mask; bit un; logic [31:0] wdata; } cexp_t;
  typedef struct { logic [31:0] data; int gap; } rexp_t;

  gexp_t gq[$];
  cexp_t cq[$];
  rexp_t rq0[$];
  rexp_t rq1[$];

  task automatic eg(input bit id, input int gap, input bit rv);
    gexp_t g;
    g.id = id; g.gap = gap; g.rv = rv;
    gq.push_back(g);
  endtask

  task automatic ec(input bit wr, input logic [31:0] a, input logic [3:0] m, input bit u,
                    input logic [31:0] d);
    cexp_t c;
    c.wr = wr; c.addr = a; c.mask = m; c.un = u; c.wdata = d;
    cq.push_back(c);
  endtask

  task automatic er(input bit id, input logic [31:0] d, input int gap);
    rexp_t r;
    r.data = d; r.gap = gap;
    if (id) rq1.push_back(r);
    else    rq0.push_back(r);
  endtask

  // lsu read-data model: data for the address issued RD_LAT cycles earlier, junk otherwise
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_7800: return 32'hA5A5_A5A5;
      32'h0000_2000: return 32'hA1A1_A1A1;
      32'h0000_2004: return 32'hB2B2_B2B2;
      32'h0000_2003: return 32'h3C3C_0003;
      default:       return 32'hDEAD_0000;
    endcase
  endfunction

  bit          ld_pend = 1'b0;
  int          ld_left = 0;
  logic [31:0] ld_addr = '0;
  always @(negedge i_clk) begin
    i_ld_data = 32'hBAD0_BAD0;
    if (ld_pend) begin
      ld_left--;
      if (ld_left == 0) begin
        i_ld_data = mem_rd(ld_addr);
        ld_pend   = 1'b0;
      end
    end
    if (o_lsu_rden) begin
      ld_pend = 1'b1;
      ld_left = RD_LAT;
      ld_addr = o_lsu_addr;
    end
  end

  int    last_gnt = 0, last_rd = 0, last_rv0 = 0, last_rv1 = 0;
  gexp_t mg;
  cexp_t mc;
  rexp_t mr;
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_m0_gnt && o_m1_gnt) chk("dual_gnt", 32'd1, 32'd0);
      if (o_m0_gnt || o_m1_gnt) begin
        if (gq.size() == 0) chk("unexpected_gnt", 32'd1, 32'd0);
        else begin
          mg = gq.pop_front();
          chk("gnt_id", {31'b0, o_m1_gnt}, {31'b0, mg.id});
          if (mg.gap != 0) chk("gnt_gap", 32'(cyc - last_gnt), 32'(mg.gap));
          chk("gnt_with_rv0", {31'b0, o_m0_rvalid}, {31'b0, mg.rv});
        end
        last_gnt = cyc;
      end
      if (o_lsu_wren || o_lsu_rden) begin
        if (cq.size() == 0) chk("unexpected_cmd", 32'd1, 32'd0);
        else begin
          mc = cq.pop_front();
          chk("cmd_wren", {31'b0, o_lsu_wren}, {31'b0, mc.wr});
          chk("cmd_rden", {31'b0, o_lsu_rden}, {31'b0, ~mc.wr});
          chk("cmd_addr", o_lsu_addr, mc.addr);
          chk("cmd_mask", {28'b0, o_lsu_mask}, {28'b0, mc.mask});
          chk("cmd_un", {31'b0, o_lsu_un}, {31'b0, mc.un});
          if (mc.wr) chk("cmd_wdata", o_st_data, mc.wdata);
          chk("cmd_after_gnt", 32'(cyc - last_gnt), 32'd1);
        end
        if (o_lsu_rden) last_rd = cyc;
      end
      if (o_m0_rvalid) begin
        if (rq0.size() == 0) chk("unexpected_rv0", 32'd1, 32'd0);
        else begin
          mr = rq0.pop_front();
          chk("rdata0", o_m0_rdata, mr.data);
          chk("rv0_latency", 32'(cyc - last_rd), 32'(RD_LAT + 1));
          if (mr.gap != 0) chk("rv0_spacing", 32'(cyc - last_rv0), 32'(mr.gap));
        end
        last_rv0 = cyc;
      end
      if (o_m1_rvalid) begin
        if (rq1.size() == 0) chk("unexpected_rv1", 32'd1, 32'd0);
        else begin
          mr = rq1.pop_front();
          chk("rdata1", o_m1_rdata, mr.data);
          chk("rv1_latency", 32'(cyc - last_rd), 32'(RD_LAT + 1));
          if (mr.gap != 0) chk("rv1_spacing", 32'(cyc - last_rv1), 32'(mr.gap));
        end
        last_rv1 = cyc;
      end
    end
  end

  task automatic xfer(input bit id, input bit wr, input logic [31:0] a, input logic [3:0] m,
                      input bit u, input logic [31:0] d);
    int n;
    if (id == 1'b0) begin
      i_m0_req = 1'b1; i_m0_wren = wr; i_m0_addr = a; i_m0_mask = m; i_m0_un = u; i_m0_wdata = d;
    end else begin
      i_m1_req = 1'b1; i_m1_wren = wr; i_m1_addr = a; i_m1_mask = m; i_m1_un = u; i_m1_wdata = d;
    end
    n = 0;
    forever begin
      @(negedge i_clk);
      if (!i_rst && (id ? o_m1_gnt : o_m0_gnt)) break;
      n++;
      if (n > 50) begin
        chk(id ? "m1_gnt_timeout" : "m0_gnt_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge i_clk);
    #1;
    if (id == 1'b0) i_m0_req = 1'b0;
    else            i_m1_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int j;
    int k;
    int w;
    i_rst = 1'b1;
    i_m0_req = 1'b1; i_m0_wren = 1'b0; i_m0_addr = '0; i_m0_mask = '0; i_m0_un = 1'b0; i_m0_wdata = '0;
    i_m1_req = 1'b0; i_m1_wren = 1'b0; i_m1_addr = '0; i_m1_mask = '0; i_m1_un = 1'b0; i_m1_wdata = '0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_busy", {31'b0, o_busy}, 32'd0);
    chk("rst_m0_gnt_masked", {31'b0, o_m0_gnt}, 32'd0);
    chk("rst_lsu_addr", o_lsu_addr, 32'd0);
    chk("rst_st_data", o_st_data, 32'd0);
    chk("rst_rdata0", o_m0_rdata, 32'd0);
    chk("rst_rdata1", o_m1_rdata, 32'd0);
    i_m0_req = 1'b0;
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;

    // 1: master-0 store
    eg(1'b0, 0, 1'b0);
    ec(1'b1, 32'h7000, 4'hF, 1'b0, 32'hFFFF_FFFF);
    xfer(1'b0, 1'b1, 32'h7000, 4'hF, 1'b0, 32'hFFFF_FFFF);
    @(posedge i_clk);
    #1;
    chk("st_busy_T2", {31'b0, o_busy}, 32'd0);
    chk("st_wren_idle", {31'b0, o_lsu_wren}, 32'd0);
    chk("st_addr_held", o_lsu_addr, 32'h7000);

    // 2: master-1 load
    eg(1'b1, 0, 1'b0);
    ec(1'b0, 32'h7800, 4'hF, 1'b0, 32'h0);
    er(1'b1, 32'hA5A5_A5A5, 0);
    xfer(1'b1, 1'b0, 32'h7800, 4'hF, 1'b0, 32'h0);
    repeat (3) @(posedge i_clk);
    #1;

    // 3: contention, all stores
    j = 0; k = 0;
    for (int i = 0; i < 10; i++) begin
      eg((i == 4 || i == 9), (i == 0) ? 0 : 2, 1'b0);
      if (i == 4 || i == 9) begin
        ec(1'b1, 32'(32'h7100 + 4 * j), 4'hF, 1'b0, 32'(32'h1111_0000 + j));
        j++;
      end else begin
        ec(1'b1, 32'(32'h1000 + 4 * k), 4'hF, 1'b0, 32'(32'h0000_1000 + k));
        k++;
      end
    end
    fork
      for (int a = 0; a < 8; a++) xfer(1'b0, 1'b1, 32'(32'h1000 + 4 * a), 4'hF, 1'b0, 32'(32'h0000_1000 + a));
      for (int b = 0; b < 2; b++) xfer(1'b1, 1'b1, 32'(32'h7100 + 4 * b), 4'hF, 1'b0, 32'(32'h1111_0000 + b));
    join
    repeat (2) @(posedge i_clk);
    #1;

    // 4: byte-control pass-through, master-1 raised during RDWAIT
    eg(1'b0, 0, 1'b0);
    ec(1'b0, 32'h2003, 4'b0001, 1'b1, 32'h0);
    er(1'b0, 32'h3C3C_0003, 0);
    eg(1'b1, 3, 1'b1);
    ec(1'b1, 32'h7200, 4'hF, 1'b0, 32'hCAFE_F00D);
    xfer(1'b0, 1'b0, 32'h2003, 4'b0001, 1'b1, 32'h0);
    @(posedge i_clk);
    #1;
    xfer(1'b1, 1'b1, 32'h7200, 4'hF, 1'b0, 32'hCAFE_F00D);
    repeat (2) @(posedge i_clk);
    #1;

    // 5: reset in RDWAIT with hold_cnt raised to 2 beforehand
    i_m1_req = 1'b1; i_m1_wren = 1'b1; i_m1_addr = 32'h7300; i_m1_mask = 4'hF; i_m1_wdata = 32'h7300_7300;
    eg(1'b0, 0, 1'b0);
    eg(1'b0, 2, 1'b0);
    ec(1'b1, 32'h1100, 4'hF, 1'b0, 32'h55AA_55AA);
    ec(1'b0, 32'h2008, 4'hF, 1'b0, 32'h0);
    xfer(1'b0, 1'b1, 32'h1100, 4'hF, 1'b0, 32'h55AA_55AA);
    xfer(1'b0, 1'b0, 32'h2008, 4'hF, 1'b0, 32'h0);
    @(posedge i_clk);
    #3;
    i_rst = 1'b1;
    #1;
    chk("arst_busy", {31'b0, o_busy}, 32'd0);
    chk("arst_lsu_addr", o_lsu_addr, 32'd0);
    chk("arst_st_data", o_st_data, 32'd0);
    chk("arst_rdata0", o_m0_rdata, 32'd0);
    chk("arst_rdata1", o_m1_rdata, 32'd0);
    chk("arst_m1_gnt_masked", {31'b0, o_m1_gnt}, 32'd0);
    i_m1_req = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    for (int i = 0; i < 5; i++) eg((i == 4), (i == 0) ? 0 : 2, 1'b0);
    for (int i = 0; i < 4; i++) ec(1'b1, 32'(32'h1200 + 4 * i), 4'hF, 1'b0, 32'(32'h0000_1200 + i));
    ec(1'b1, 32'h7300, 4'hF, 1'b0, 32'h7300_7300);
    fork
      for (int a = 0; a < 4; a++) xfer(1'b0, 1'b1, 32'(32'h1200 + 4 * a), 4'hF, 1'b0, 32'(32'h0000_1200 + a));
      xfer(1'b1, 1'b1, 32'h7300, 4'hF, 1'b0, 32'h7300_7300);
    join
    repeat (3) @(posedge i_clk);
    #1;

    // 6: back-to-back master-0 loads
    eg(1'b0, 0, 1'b0);
    eg(1'b0, 3, 1'b1);
    ec(1'b0, 32'h2000, 4'hF, 1'b0, 32'h0);
    ec(1'b0, 32'h2004, 4'hF, 1'b0, 32'h0);
    er(1'b0, 32'hA1A1_A1A1, 0);
    er(1'b0, 32'hB2B2_B2B2, 3);
    xfer(1'b0, 1'b0, 32'h2000, 4'hF, 1'b0, 32'h0);
    xfer(1'b0, 1'b0, 32'h2004, 4'hF, 1'b0, 32'h0);

    w = 0;
    while ((gq.size() + cq.size() + rq0.size() + rq1.size()) != 0 && w < 50) begin
      @(posedge i_clk);
      w++;
    end
    repeat (2) @(posedge i_clk);
    #1;
    chk("queues_drained", 32'(gq.size() + cq.size() + rq0.size() + rq1.size()), 32'd0);
    chk("end_rdata0_held", o_m0_rdata, 32'hB2B2_B2B2);
    chk("end_rdata1_cleared", o_m1_rdata, 32'd0);
    chk("end_busy", {31'b0, o_busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
